// File: rtl/uart_loop_fifo.sv
// Byte FIFO between the UART receiver and transmitter in the loopback top.
// Buffers received bytes and replays them one at a time over a trigger/busy handshake.
module uart_loop_fifo #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 4,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              iclk,
    input  logic              ireset_n,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_err,
    input  logic              tx_busy,
    input  logic              clear_flags,
    output logic              tx_trig,
    output logic [DATA_W-1:0] tx_data,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              err_drop,
    output logic              tx_lost
);
    // state       | meaning
    // S_IDLE      | no byte in flight; pops and triggers as soon as the FIFO holds a byte
    // S_WAIT_BUSY | trigger issued; waiting up to BUSY_TIMEOUT cycles for tx_busy to rise
    // S_WAIT_DONE | transmitter shifting; waiting for tx_busy to fall

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam int              TMR_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(BUSY_TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_TC   = TMR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_BUSY = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic [TMR_W-1:0]    r_tmr;
    logic                r_tx_trig;
    logic [DATA_W-1:0]   r_tx_data;
    logic                r_overflow;
    logic                r_err_drop;
    logic                r_tx_lost;
    logic                w_pop;
    logic                w_push;
    logic                w_ovf_set;
    logic                w_err_set;
    logic                w_timeout;

    assign count    = r_count;
    assign empty    = (r_count == '0);
    assign full     = r_count[ADDR_W];   // count never exceeds DEPTH, so the MSB alone means full
    assign tx_trig  = r_tx_trig;
    assign tx_data  = r_tx_data;
    assign overflow = r_overflow;
    assign err_drop = r_err_drop;
    assign tx_lost  = r_tx_lost;

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) r_state <= S_IDLE;
        else           r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (!empty) w_state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                if (tx_busy)               w_state_nxt = S_WAIT_DONE;
                else if (r_tmr == TMR_TC)  w_state_nxt = S_IDLE;
            end
            S_WAIT_DONE: if (!tx_busy) w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop     = (r_state == S_IDLE) && !empty;
        w_timeout = (r_state == S_WAIT_BUSY) && !tx_busy && (r_tmr == TMR_TC);
        // a pop in the same edge frees a slot, so a full FIFO can still accept
        w_push    = rx_valid && !rx_err && (!full || w_pop);
        w_ovf_set = rx_valid && !rx_err && full && !w_pop;
        w_err_set = rx_valid && rx_err;
    end

    always_ff @(posedge iclk) begin
        if (w_push) r_mem[r_wr_ptr] <= rx_data;
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_tmr      <= '0;
            r_tx_trig  <= 1'b0;
            r_tx_data  <= '0;
            r_overflow <= 1'b0;
            r_err_drop <= 1'b0;
            r_tx_lost  <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_tx_trig <= w_pop;
            if (w_pop) r_tx_data <= r_mem[r_rd_ptr];
            if (w_pop)                                        r_tmr <= TMR_LOAD;
            else if (r_state == S_WAIT_BUSY && r_tmr != '0)   r_tmr <= r_tmr - 1'b1;
            r_overflow <= w_ovf_set | (r_overflow & ~clear_flags);
            r_err_drop <= w_err_set | (r_err_drop & ~clear_flags);
            r_tx_lost  <= w_timeout | (r_tx_lost  & ~clear_flags);
        end
    end
endmodule

// File: tb/tb_uart_loop_fifo.sv
// Self-checking bench for uart_loop_fifo: directed scenarios plus random traffic,
// all checked against a queue-based transaction model.
module tb_uart_loop_fifo;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int TO    = 16;
    localparam int DEPTH = 16;
    localparam logic [18:0] RST_VEC = {1'b0, 8'h00, 5'd0, 1'b1, 1'b0, 3'b000};

    logic          iclk = 1'b0;
    logic          ireset_n = 1'b1;
    logic          rx_valid = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_err = 1'b0;
    logic          tx_busy = 1'b0;
    logic          clear_flags = 1'b0;
    logic          tx_trig;
    logic [DW-1:0] tx_data;
    logic [AW:0]   count;
    logic          empty, full, overflow, err_drop, tx_lost;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    uart_loop_fifo #(.DATA_W(DW), .ADDR_W(AW), .BUSY_TIMEOUT(TO)) dut (
        .iclk(iclk), .ireset_n(ireset_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_err(rx_err), .tx_busy(tx_busy), .clear_flags(clear_flags),
        .tx_trig(tx_trig), .tx_data(tx_data), .count(count), .empty(empty), .full(full),
        .overflow(overflow), .err_drop(err_drop), .tx_lost(tx_lost)
    );

    always #5 iclk = ~iclk;

    // reference model: byte queue, in-flight phase, cycles spent waiting for busy
    logic [7:0] m_q[$];
    logic [7:0] exp_log[$];
    logic [7:0] dut_log[$];
    int         m_phase;
    int         m_wait;
    logic       m_trig;
    logic [7:0] m_data;
    logic       m_ovf, m_err, m_lost;

    // transmitter stand-in: 0 = respond after busy_dly for busy_len cycles, 1 = stuck high, 2 = stuck low
    int busy_mode = 0;
    int busy_dly = 2;
    int busy_len = 10;
    int bwait = 0;
    int bhold = 0;
    bit rand_busy = 0;

    task automatic model_reset();
        m_q.delete();
        exp_log.delete();
        dut_log.delete();
        m_phase = 0; m_wait = 0; m_trig = 0; m_data = '0;
        m_ovf = 0; m_err = 0; m_lost = 0;
    endtask

    task automatic model_step();
        if (clear_flags) begin m_ovf = 0; m_err = 0; m_lost = 0; end
        m_trig = 0;
        case (m_phase)
            0: if (m_q.size() > 0) begin
                m_data = m_q.pop_front();
                exp_log.push_back(m_data);
                m_trig = 1; m_phase = 1; m_wait = 0;
            end
            1: if (tx_busy) m_phase = 2;
               else begin
                   m_wait++;
                   if (m_wait >= TO) begin m_lost = 1; m_phase = 0; end
               end
            2: if (!tx_busy) m_phase = 0;
            default: m_phase = 0;
        endcase
        if (rx_valid) begin
            if (rx_err)                 m_err = 1;
            else if (m_q.size() < DEPTH) m_q.push_back(rx_data);
            else                        m_ovf = 1;
        end
    endtask

    function automatic logic [18:0] model_vec();
        return {m_trig, m_data, 5'(m_q.size()), m_q.size() == 0, m_q.size() == DEPTH,
                m_ovf, m_err, m_lost};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {tx_trig, tx_data, count, empty, full, overflow, err_drop, tx_lost};
    endfunction

    task automatic responder_step();
        case (busy_mode)
            1: tx_busy = 1'b1;
            2: tx_busy = 1'b0;
            default: begin
                if (tx_trig) begin
                    if (rand_busy) begin
                        busy_dly = $urandom_range(0, 20);
                        busy_len = $urandom_range(1, 6);
                    end
                    if (busy_dly == 0) bhold = busy_len;
                    else               bwait = busy_dly;
                end else if (bwait > 0) begin
                    bwait--;
                    if (bwait == 0) bhold = busy_len;
                end
                tx_busy = (bhold > 0);
                if (bhold > 0) bhold--;
            end
        endcase
    endtask

    task automatic tick();
        @(posedge iclk);
        model_step();
        @(negedge iclk);
        cyc++;
        if (tx_trig) dut_log.push_back(tx_data);
        responder_step();
    endtask

    task automatic do_reset();
        @(negedge iclk);
        ireset_n = 1'b0;
        rx_valid = 0; rx_err = 0; rx_data = '0; clear_flags = 0;
        bwait = 0; bhold = 0; tx_busy = 0; rand_busy = 0;
        model_reset();
        repeat (2) @(negedge iclk);
        ireset_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 ireset_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec() !== RST_VEC) begin
            n_bad++; $display("FAIL reset_vals got %h want %h", dut_vec(), RST_VEC);
        end
        model_reset();
        @(negedge iclk);
        ireset_n = 1'b1;
        repeat (3) begin
            tick();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++; $display("FAIL reset_idle got %h want %h", dut_vec(), model_vec());
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        busy_mode = 0; busy_dly = 2; busy_len = 10;
        rx_valid = 1; rx_data = 8'h0D;
        tick();
        rx_valid = 0;
        n_cmp++;
        if ({count, empty, tx_trig} !== {5'd1, 1'b0, 1'b0}) begin
            n_bad++; $display("FAIL single_push got %h want %h", {count, empty, tx_trig}, {5'd1, 2'b00});
        end
        tick();
        n_cmp++;
        if ({tx_trig, tx_data, count} !== {1'b1, 8'h0D, 5'd0}) begin
            n_bad++; $display("FAIL single_trig got %h want %h", {tx_trig, tx_data, count}, {1'b1, 8'h0D, 5'd0});
        end
        repeat (30) begin
            tick();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++; $display("FAIL single_cyc t=%0t got %h want %h", $time, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (dut_log.size() !== 1 || dut_log[0] !== 8'h0D || empty !== 1'b1) begin
            n_bad++; $display("FAIL single_once got n=%0d empty=%b want n=1 byte=0d empty=1", dut_log.size(), empty);
        end
    endtask

    task automatic test_burst();
        int peak = 0;
        do_reset();
        busy_mode = 1;
        for (int i = 0; i < 5; i++) begin
            rx_valid = 1; rx_data = 8'(i + 1);
            tick();
            if (int'(count) > peak) peak = int'(count);
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++; $display("FAIL burst_push i=%0d got %h want %h", i, dut_vec(), model_vec());
            end
        end
        rx_valid = 0;
        n_cmp++;
        if (peak !== 4) begin
            n_bad++; $display("FAIL burst_peak got %0d want 4", peak);
        end
        busy_mode = 0; busy_dly = 2; busy_len = 4;
        repeat (80) begin
            tick();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++; $display("FAIL burst_cyc t=%0t got %h want %h", $time, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (dut_log.size() !== 5) begin
            n_bad++; $display("FAIL burst_n got %0d want 5", dut_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (dut_log[i] !== 8'(i + 1)) begin
                    n_bad++; $display("FAIL burst_order i=%0d got %h want %h", i, dut_log[i], 8'(i + 1));
                end
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        busy_mode = 1;
        for (int i = 0; i < 18; i++) begin
            rx_valid = 1; rx_data = 8'(8'h10 + i);
            tick();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++; $display("FAIL ovf_push i=%0d got %h want %h", i, dut_vec(), model_vec());
            end
        end
        rx_valid = 0;
        n_cmp++;
        if ({full, count, overflow} !== {1'b1, 5'd16, 1'b1}) begin
            n_bad++; $display("FAIL ovf_full got %h want %h", {full, count, overflow}, {1'b1, 5'd16, 1'b1});
        end
        busy_mode = 0; busy_dly = 1; busy_len = 3;
        repeat (300) begin
            tick();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++; $display("FAIL ovf_cyc t=%0t got %h want %h", $time, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (dut_log.size() !== 17) begin
            n_bad++; $display("FAIL ovf_n got %0d want 17", dut_log.size());
        end else begin
            for (int i = 0; i < 17; i++) begin
                n_cmp++;
                if (dut_log[i] !== 8'(8'h10 + i)) begin
                    n_bad++; $display("FAIL ovf_order i=%0d got %h want %h", i, dut_log[i], 8'(8'h10 + i));
                end
            end
        end
    endtask

    task automatic test_err_clear();
        do_reset();
        busy_mode = 0; busy_dly = 2; busy_len = 3;
        rx_valid = 1; rx_err = 1; rx_data = 8'hAA;
        tick();
        rx_valid = 0; rx_err = 0;
        n_cmp++;
        if ({err_drop, count} !== {1'b1, 5'd0}) begin
            n_bad++; $display("FAIL err_set got %h want %h", {err_drop, count}, {1'b1, 5'd0});
        end
        tick();
        n_cmp++;
        if ({tx_trig, err_drop, count} !== {1'b0, 1'b1, 5'd0}) begin
            n_bad++; $display("FAIL err_nowrite got %h want %h", {tx_trig, err_drop, count}, {2'b01, 5'd0});
        end
        clear_flags = 1;
        tick();
        clear_flags = 0;
        n_cmp++;
        if (err_drop !== 1'b0) begin
            n_bad++; $display("FAIL err_clear got %b want 0", err_drop);
        end
        n_cmp++;
        if (dut_vec() !== model_vec()) begin
            n_bad++; $display("FAIL err_cyc got %h want %h", dut_vec(), model_vec());
        end
    endtask

    task automatic test_timeout();
        int trig_at = -1;
        int lost_at = -1;
        do_reset();
        busy_mode = 2;
        rx_valid = 1; rx_data = 8'h55;
        tick();
        rx_valid = 0;
        repeat (40) begin
            tick();
            if (tx_trig && trig_at < 0) trig_at = cyc;
            if (tx_lost && lost_at < 0) lost_at = cyc;
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++; $display("FAIL tmo_cyc t=%0t got %h want %h", $time, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (trig_at < 0 || lost_at - trig_at !== TO) begin
            n_bad++; $display("FAIL tmo_delay got %0d want %0d", lost_at - trig_at, TO);
        end
        n_cmp++;
        if ({count, empty, tx_lost} !== {5'd0, 1'b1, 1'b1}) begin
            n_bad++; $display("FAIL tmo_state got %h want %h", {count, empty, tx_lost}, {5'd0, 2'b11});
        end
        // back in idle: a new byte must trigger one cycle after its push
        rx_valid = 1; rx_data = 8'h66;
        tick();
        rx_valid = 0;
        tick();
        n_cmp++;
        if ({tx_trig, tx_data} !== {1'b1, 8'h66}) begin
            n_bad++; $display("FAIL tmo_idle got %h want %h", {tx_trig, tx_data}, {1'b1, 8'h66});
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        busy_mode = 1;
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1; rx_data = 8'(8'hC0 + i);
            tick();
        end
        rx_valid = 0;
        tick();
        n_cmp++;
        if (count !== 5'd3) begin
            n_bad++; $display("FAIL arst_pre got %0d want 3", count);
        end
        #2 ireset_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec() !== RST_VEC) begin
            n_bad++; $display("FAIL arst_vals got %h want %h", dut_vec(), RST_VEC);
        end
        model_reset();
        busy_mode = 0; bwait = 0; bhold = 0;
        @(negedge iclk);
        ireset_n = 1'b1;
    endtask

    task automatic test_random();
        int nerr_log = 0;
        do_reset();
        busy_mode = 0; rand_busy = 1; busy_dly = 3; busy_len = 2;
        repeat (3000) begin
            rx_valid    = ($urandom_range(0, 99) < 60);
            rx_err      = ($urandom_range(0, 99) < 10);
            rx_data     = 8'($urandom);
            clear_flags = ($urandom_range(0, 99) < 3);
            tick();
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_bad++; $display("FAIL rand_cyc t=%0t got %h want %h", $time, dut_vec(), model_vec());
            end
        end
        rx_valid = 0; rx_err = 0; clear_flags = 0;
        n_cmp++;
        if (dut_log.size() !== exp_log.size()) begin
            n_bad++; $display("FAIL rand_n got %0d want %0d", dut_log.size(), exp_log.size());
        end else begin
            for (int i = 0; i < exp_log.size(); i++) begin
                n_cmp++;
                if (dut_log[i] !== exp_log[i]) begin
                    n_bad++;
                    if (nerr_log < 10) $display("FAIL rand_order i=%0d got %h want %h", i, dut_log[i], exp_log[i]);
                    nerr_log++;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_burst();
        test_overflow();
        test_err_clear();
        test_timeout();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
